// File: rtl/mac_seq.sv
// mac_seq: sequencer that drives a MAC accumulator slice.
// Accepts TAPS operand pairs, clears the MAC, feeds each pair, waits for the
// final accumulation to land, then offers the dot product on a result port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. In_Ready_SO and Res_Valid_SO decode the registered state only,
// so neither depends combinationally on any input. A source may hold
// In_Valid_SI at any time; data is consumed only while In_Ready_SO is high.
// The result stays stable until the edge where Res_Ready_SI is seen high.
module mac_seq #(
    parameter int WIDTH     = 24,
    parameter int IN_WIDTH  = 12,
    parameter int TAPS      = 16,
    parameter int CNT_WIDTH = 4
) (
    input  logic                Clk_CI,
    input  logic                Rst_RBI,
    input  logic                Start_SI,
    output logic                Busy_SO,
    input  logic                In_Valid_SI,
    output logic                In_Ready_SO,
    input  logic [IN_WIDTH-1:0] In0_DI,
    input  logic [IN_WIDTH-1:0] In1_DI,
    output logic                Mac_Clr_SO,
    output logic                Mac_WrEn_SO,
    output logic [IN_WIDTH-1:0] Mac_In0_DO,
    output logic [IN_WIDTH-1:0] Mac_In1_DO,
    input  logic [WIDTH-1:0]    Mac_Out_DI,
    output logic                Res_Valid_SO,
    input  logic                Res_Ready_SI,
    output logic [WIDTH-1:0]    Res_DO
);

    // Sequence: IDLE -> CLR -> ACC (TAPS pairs) -> FLUSH -> CAPT -> OUT.
    // r_state is the debug handle for checkers bound to this block.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ACC   = 3'd2,
        S_FLUSH = 3'd3,
        S_CAPT  = 3'd4,
        S_OUT   = 3'd5
    } state_e;

    localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(TAPS - 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_in_ready;
    logic                 w_in_hs;
    logic                 w_last;

    logic                 r_mac_clr;
    logic                 r_mac_wren;
    logic [IN_WIDTH-1:0]  r_mac_in0;
    logic [IN_WIDTH-1:0]  r_mac_in1;
    logic [WIDTH-1:0]     r_res;

    assign w_in_ready = (r_state == S_ACC);
    assign w_in_hs    = In_Valid_SI & w_in_ready;
    assign w_last     = (r_cnt == LastCnt);

    // Next-state and tap-counter decode; defaults hold the current values.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (Start_SI) w_state_nxt = S_CLR;
            end
            S_CLR: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_ACC;
            end
            S_ACC: begin
                if (w_in_hs) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last) w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: w_state_nxt = S_CAPT;
            S_CAPT:  w_state_nxt = S_OUT;
            S_OUT: begin
                // A Start coincident with the result handshake chains straight into CLR.
                if (Res_Ready_SI) w_state_nxt = Start_SI ? S_CLR : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and tap counter registers.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // MAC-side flops: clear+write in CLR, one write the cycle after each
    // accepted pair (the last one lands in FLUSH), operands held otherwise.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_mac_clr  <= 1'b0;
            r_mac_wren <= 1'b0;
            r_mac_in0  <= '0;
            r_mac_in1  <= '0;
        end else begin
            r_mac_clr  <= (w_state_nxt == S_CLR);
            r_mac_wren <= (w_state_nxt == S_CLR) | w_in_hs;
            if (w_in_hs) begin
                r_mac_in0 <= In0_DI;
                r_mac_in1 <= In1_DI;
            end
        end
    end

    // Result capture: the accumulator has absorbed the last pair by CAPT.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_res <= '0;
        end else if (r_state == S_CAPT) begin
            r_res <= Mac_Out_DI;
        end
    end

    assign Busy_SO      = (r_state != S_IDLE);
    assign In_Ready_SO  = w_in_ready;
    assign Res_Valid_SO = (r_state == S_OUT);
    assign Mac_Clr_SO   = r_mac_clr;
    assign Mac_WrEn_SO  = r_mac_wren;
    assign Mac_In0_DO   = r_mac_in0;
    assign Mac_In1_DO   = r_mac_in1;
    assign Res_DO       = r_res;

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: a TAPS=4 instance (main) and a TAPS=1 instance, each
// with a behavioural MAC. Expected dot products come from plain arithmetic on
// the issued pairs and are queued; monitors pop them on each result handshake.
module tb_mac_seq;

    localparam int W   = 24;
    localparam int IW  = 12;
    localparam int T0  = 4;
    localparam int CW0 = 2;
    localparam int T1  = 1;
    localparam int CW1 = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance (TAPS=4) ----------------
    logic          start = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
    logic [IW-1:0] in_a = '0, in_b = '0;
    logic          busy, in_ready, mac_clr, mac_wren, res_valid;
    logic [IW-1:0] mac_a, mac_b;
    logic [W-1:0]  mac_out, res_do;

    mac_seq #(.WIDTH(W), .IN_WIDTH(IW), .TAPS(T0), .CNT_WIDTH(CW0)) u_dut (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Busy_SO(busy),
        .In_Valid_SI(in_valid), .In_Ready_SO(in_ready), .In0_DI(in_a), .In1_DI(in_b),
        .Mac_Clr_SO(mac_clr), .Mac_WrEn_SO(mac_wren), .Mac_In0_DO(mac_a), .Mac_In1_DO(mac_b),
        .Mac_Out_DI(mac_out), .Res_Valid_SO(res_valid), .Res_Ready_SI(res_ready), .Res_DO(res_do)
    );

    // ---------------- TAPS=1 instance ----------------
    logic          start_1 = 1'b0, in_valid_1 = 1'b0, res_ready_1 = 1'b0;
    logic [IW-1:0] in_a_1 = '0, in_b_1 = '0;
    logic          busy_1, in_ready_1, mac_clr_1, mac_wren_1, res_valid_1;
    logic [IW-1:0] mac_a_1, mac_b_1;
    logic [W-1:0]  mac_out_1, res_do_1;

    mac_seq #(.WIDTH(W), .IN_WIDTH(IW), .TAPS(T1), .CNT_WIDTH(CW1)) u_dut_1 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start_1), .Busy_SO(busy_1),
        .In_Valid_SI(in_valid_1), .In_Ready_SO(in_ready_1), .In0_DI(in_a_1), .In1_DI(in_b_1),
        .Mac_Clr_SO(mac_clr_1), .Mac_WrEn_SO(mac_wren_1), .Mac_In0_DO(mac_a_1), .Mac_In1_DO(mac_b_1),
        .Mac_Out_DI(mac_out_1), .Res_Valid_SO(res_valid_1), .Res_Ready_SI(res_ready_1), .Res_DO(res_do_1)
    );

    // Behavioural MAC slices: clear wins, otherwise accumulate modulo 2^W.
    logic [W-1:0] mac_acc = '0, mac_acc_1 = '0;
    always @(posedge clk) begin
        if (mac_wren) mac_acc <= mac_clr ? '0 : mac_acc + W'(mac_a) * W'(mac_b);
        if (mac_wren_1) mac_acc_1 <= mac_clr_1 ? '0 : mac_acc_1 + W'(mac_a_1) * W'(mac_b_1);
    end
    assign mac_out   = mac_acc;
    assign mac_out_1 = mac_acc_1;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_q1[$];
    int n_checks = 0;
    int n_pass = 0;
    int wren_cnt = 0, clr_cnt = 0, wren_base = 0, clr_base = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // Monitor: pops the expected result on every result handshake and
    // tallies MAC write/clear pulses of the main instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mac_wren) wren_cnt++;
            if (mac_clr) begin
                clr_cnt++;
                check("clr_context", {busy, in_ready, res_valid, mac_wren}, 4'b1001);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL res_unexpected: got 0x%0h expected none", res_do);
                end else begin
                    check("res_do", res_do, exp_q.pop_front());
                end
            end
            if (res_valid_1 && res_ready_1) begin
                if (exp_q1.size() == 0) begin
                    n_checks++;
                    $display("FAIL res1_unexpected: got 0x%0h expected none", res_do_1);
                end else begin
                    check("res1_do", res_do_1, exp_q1.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [IW-1:0] pa[T0];
    logic [IW-1:0] pb[T0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [IW-1:0] a, input logic [IW-1:0] b, input int gap, input bit poke);
        int n;
        if (poke) begin
            // Start inside ACC must be ignored.
            start = 1'b1; in_valid = 1'b0;
            tick();
            start = 1'b0;
            check("acc_start_ignored_wren", mac_wren, 0);
        end
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            tick();
            check("gap_no_wren", mac_wren, 0);
        end
        in_valid = 1'b1; in_a = a; in_b = b;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("in_ready_timeout", n, 0);
        tick();
        in_valid = 1'b0; in_a = IW'($urandom); in_b = IW'($urandom);
        check("mac_operands", {mac_a, mac_b}, {a, b});
        check("wren_after_hs", mac_wren, 1);
    endtask

    task automatic recv(input int hold, input bit chain);
        logic [W-1:0] r0;
        r0 = res_do;
        for (int i = 0; i < hold; i++) begin
            check("out_hold_valid", res_valid, 1);
            check("out_hold_data", res_do, r0);
            check("out_no_in_ready", in_ready, 0);
            check("out_no_wren", mac_wren, 0);
            in_valid = 1'b1; in_a = IW'($urandom); in_b = IW'($urandom);
            tick();
        end
        res_ready = 1'b1;
        if (chain) begin
            start = 1'b1;
            wren_base = wren_cnt;
            clr_base = clr_cnt;
        end
        tick();
        res_ready = 1'b0; start = 1'b0;
        check("valid_one_cycle", res_valid, 0);
        if (!chain) begin
            check("idle_after_out", busy, 0);
            in_valid = 1'b0;
        end
    endtask

    task automatic run_txn(input int gmin, input int gmax, input int hold,
                           input bit poke, input bit chained, input bit chain_next);
        logic [63:0] sum;
        int k;
        sum = 0;
        for (int i = 0; i < T0; i++) sum += 64'(pa[i]) * 64'(pb[i]);
        if (!chained) begin
            wren_base = wren_cnt;
            clr_base = clr_cnt;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("clr_pulse", {mac_clr, mac_wren, in_ready}, 3'b110);
        tick();
        check("acc_ready_after_2", {in_ready, mac_clr}, 2'b10);
        for (int i = 0; i < T0; i++)
            send_pair(pa[i], pb[i], $urandom_range(gmax, gmin), poke && (i == 1));
        exp_q.push_back(sum[W-1:0]);
        k = 0;
        if (poke) start = 1'b1;   // Start inside FLUSH must be ignored.
        while (!res_valid && k < 20) begin
            tick();
            start = 1'b0;
            k++;
        end
        check("result_latency", k, 2);
        check("wren_pulses", wren_cnt - wren_base, T0 + 1);
        check("clr_pulses", clr_cnt - clr_base, 1);
        recv(hold, chain_next);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit chain, next_chain;
        repeat (2) tick();
        check("reset_outputs", {busy, in_ready, mac_clr, mac_wren, mac_a, mac_b, res_valid, res_do}, 0);
        check("reset_outputs_1", {busy_1, in_ready_1, mac_clr_1, mac_wren_1, res_valid_1, res_do_1}, 0);
        rst_n = 1'b1;
        tick();

        // Back-to-back pairs, ready held high: 100, one-cycle valid.
        pa = '{12'd1, 12'd3, 12'd5, 12'd7};
        pb = '{12'd2, 12'd4, 12'd6, 12'd8};
        res_ready = 1'b1;
        run_txn(0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Two-cycle gaps, result held for 5 cycles.
        run_txn(2, 2, 5, 1'b0, 1'b0, 1'b0);

        // Starts in ACC/FLUSH ignored; Start on the OUT handshake chains.
        run_txn(0, 1, 1, 1'b1, 1'b0, 1'b1);
        pa = '{12'd2, 12'd2, 12'd2, 12'd2};
        pb = '{12'd2, 12'd2, 12'd2, 12'd2};
        run_txn(0, 1, 0, 1'b0, 1'b1, 1'b0);

        // Full-scale operands wrap modulo 2^W.
        pa = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        pb = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        run_txn(0, 2, 2, 1'b0, 1'b0, 1'b0);

        // In_Valid in IDLE consumes nothing.
        in_valid = 1'b1; in_a = 12'h123; in_b = 12'h456;
        wren_base = wren_cnt;
        repeat (5) tick();
        check("idle_no_accept", {busy, in_ready}, 2'b00);
        check("idle_no_wren", wren_cnt - wren_base, 0);
        in_valid = 1'b0;

        // Reset mid-run: outputs drop at once, next run is clean.
        pa = '{12'd9, 12'd9, 12'd9, 12'd9};
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        send_pair(12'd9, 12'd9, 0, 1'b0);
        send_pair(12'd9, 12'd9, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", {busy, in_ready, mac_clr, mac_wren, mac_a, mac_b, res_valid, res_do}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        pa = '{12'd1, 12'd1, 12'd1, 12'd1};
        pb = '{12'd1, 12'd1, 12'd1, 12'd1};
        run_txn(0, 1, 1, 1'b0, 1'b0, 1'b0);

        // Randomized runs.
        chain = 1'b0;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < T0; i++) begin
                pa[i] = ($urandom_range(3, 0) == 0) ? 12'hFFF : IW'($urandom_range(4095, 0));
                pb[i] = ($urandom_range(3, 0) == 0) ? 12'hFFF : IW'($urandom_range(4095, 0));
            end
            next_chain = (t < 19) ? 1'($urandom_range(1, 0)) : 1'b0;
            run_txn(0, 3, $urandom_range(4, 0), 1'($urandom_range(1, 0)), chain, next_chain);
            chain = next_chain;
        end

        // TAPS=1: the first handshake goes straight to FLUSH.
        for (int t = 0; t < 4; t++) begin
            int a, b;
            a = (t == 0) ? 4095 : $urandom_range(4095, 0);
            b = (t == 0) ? 4095 : $urandom_range(4095, 0);
            start_1 = 1'b1; in_valid_1 = 1'b1; in_a_1 = IW'(a); in_b_1 = IW'(b);
            tick();
            start_1 = 1'b0;
            check("t1_clr", {mac_clr_1, in_ready_1}, 2'b10);
            tick();
            check("t1_acc", in_ready_1, 1);
            exp_q1.push_back(W'(a * b));
            tick();
            in_valid_1 = 1'b0;
            check("t1_flush", {mac_wren_1, in_ready_1, mac_a_1, mac_b_1}, {1'b1, 1'b0, IW'(a), IW'(b)});
            tick();
            tick();
            check("t1_res_valid", res_valid_1, 1);
            res_ready_1 = 1'b1;
            tick();
            res_ready_1 = 1'b0;
            check("t1_idle", {busy_1, res_valid_1}, 2'b00);
        end

        tick();
        check("exp_q_drained", exp_q.size(), 0);
        check("exp_q1_drained", exp_q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
